// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words into instruction
// memory, verifies an XOR checksum, and holds the fetch PC in reset until a load succeeds.
module imem_loader #(
   parameter int ADDR_WIDTH = 11,
   parameter int MAX_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [31:0]           mem_wdata,
   output logic                  core_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            fsm_state
);

   // Stream handshake: a byte transfers on any rising clock edge where
   // s_valid and s_ready are both high; s_ready never depends on s_valid.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN0  = 3'd1,
      S_LEN1  = 3'd2,
      S_DATA  = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t                state_q, state_nx;
   logic [15:0]           count_q, count_nx;
   logic [1:0]            byte_idx_q, byte_idx_nx;
   logic [15:0]           word_idx_q, word_idx_nx;
   logic [23:0]           lane_q, lane_nx;
   logic [7:0]            csum_q, csum_nx;

   logic                  s_ready_nx;
   logic                  mem_we_nx;
   logic [ADDR_WIDTH-1:0] mem_waddr_nx;
   logic [31:0]           mem_wdata_nx;
   logic                  core_reset_nx;
   logic                  busy_nx;
   logic                  done_nx;
   logic                  error_nx;

   logic                  accept;
   logic [15:0]           n_rx;

   assign accept    = s_valid & s_ready;
   assign n_rx      = {s_data, count_q[7:0]};
   assign fsm_state = state_q;

   always_comb begin
      state_nx     = state_q;
      count_nx     = count_q;
      byte_idx_nx  = byte_idx_q;
      word_idx_nx  = word_idx_q;
      lane_nx      = lane_q;
      csum_nx      = csum_q;
      mem_we_nx    = 1'b0;
      mem_waddr_nx = mem_waddr;
      mem_wdata_nx = mem_wdata;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_nx    = S_LEN0;
               csum_nx     = 8'h00;
               byte_idx_nx = 2'd0;
               word_idx_nx = 16'd0;
            end
         end
         S_LEN0: begin
            if (accept) begin
               count_nx = {count_q[15:8], s_data};
               state_nx = S_LEN1;
            end
         end
         S_LEN1: begin
            if (accept) begin
               count_nx = n_rx;
               if ({1'b0, n_rx} > MAX_N) begin
                  state_nx = S_ERROR;
               end else if (n_rx == 16'd0) begin
                  state_nx = S_CHECK;
               end else begin
                  state_nx = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_nx     = csum_q ^ s_data;
               byte_idx_nx = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: lane_nx[7:0]   = s_data;
                  2'd1: lane_nx[15:8]  = s_data;
                  2'd2: lane_nx[23:16] = s_data;
                  default: begin
                     // Fourth byte completes the word; it goes straight to memory.
                     mem_we_nx    = 1'b1;
                     mem_waddr_nx = {word_idx_q[ADDR_WIDTH-3:0], 2'b00};
                     mem_wdata_nx = {s_data, lane_q};
                     word_idx_nx  = word_idx_q + 16'd1;
                     if (word_idx_q == count_q - 16'd1) begin
                        state_nx = S_CHECK;
                     end
                  end
               endcase
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_nx = (s_data == csum_q) ? S_DONE : S_ERROR;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // Status outputs are registered copies of what the next state implies.
      busy_nx       = (state_nx == S_LEN0) || (state_nx == S_LEN1) ||
                      (state_nx == S_DATA) || (state_nx == S_CHECK);
      s_ready_nx    = busy_nx;
      core_reset_nx = (state_nx != S_DONE);
      done_nx       = (state_nx == S_DONE);
      error_nx      = (state_nx == S_ERROR);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         count_q    <= 16'd0;
         byte_idx_q <= 2'd0;
         word_idx_q <= 16'd0;
         lane_q     <= 24'd0;
         csum_q     <= 8'h00;
         s_ready    <= 1'b0;
         mem_we     <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= 32'd0;
         core_reset <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_q    <= state_nx;
         count_q    <= count_nx;
         byte_idx_q <= byte_idx_nx;
         word_idx_q <= word_idx_nx;
         lane_q     <= lane_nx;
         csum_q     <= csum_nx;
         s_ready    <= s_ready_nx;
         mem_we     <= mem_we_nx;
         mem_waddr  <= mem_waddr_nx;
         mem_wdata  <= mem_wdata_nx;
         core_reset <= core_reset_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         error      <= error_nx;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte-stream driver, write scoreboard
// fed from the driven stream, and per-scenario status checks.
module tb_imem_loader;

   localparam int AW = 11;

   logic          clock   = 1'b0;
   logic          reset   = 1'b0;
   logic          start   = 1'b0;
   logic          s_valid = 1'b0;
   logic [7:0]    s_data  = 8'h00;
   logic          s_ready;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;
   logic          core_reset;
   logic          busy;
   logic          done;
   logic          error;
   logic [2:0]    fsm_state;

   int assertions  = 0;
   int failures    = 0;
   int writes_seen = 0;

   logic [AW+31:0] exp_q[$];
   logic [31:0]    words[0:511];

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .core_reset (core_reset),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .fsm_state  (fsm_state)
   );

   always #5 clock = ~clock;

   // One clock cycle: sample at the falling edge (scoreboard + ready), then
   // return 1 time unit after the next rising edge.
   task automatic tick(output logic rdy);
      logic [AW+31:0] exp_item;
      @(negedge clock);
      rdy = s_ready;
      if (reset && mem_we) begin
         writes_seen++;
         assertions++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_waddr, mem_wdata);
         end else begin
            exp_item = exp_q.pop_front();
            if ({mem_waddr, mem_wdata} !== exp_item) begin
               failures++;
               $display("FAIL write_content: got addr=%h data=%h, required addr=%h data=%h",
                        mem_waddr, mem_wdata, exp_item[AW+31:32], exp_item[31:0]);
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      logic r;
      repeat (n) tick(r);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      idle(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      logic r;
      bit   ok;
      ok = 1'b0;
      s_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) tick(r);
      s_valid = 1'b1;
      s_data  = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick(r);
         if (r) ok = 1'b1;
      end
      s_valid = 1'b0;
      assertions++;
      if (!ok) begin
         failures++;
         $display("FAIL byte_accept: byte %h not accepted within 20 cycles, required acceptance", b);
      end
   endtask

   // Sends count, payload from words[] and checksum (xor-ed with csum_flip);
   // every completed word is pushed to the scoreboard as it is driven.
   task automatic send_load(input int n, input logic [7:0] csum_flip, input int gap_max);
      logic [7:0]    cs;
      logic [7:0]    b;
      logic [AW-1:0] a;
      cs = 8'h00;
      send_byte(n[7:0], gap_max);
      send_byte(n[15:8], gap_max);
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) begin
            b  = words[w][8*k +: 8];
            cs = cs ^ b;
            if (k == 3) begin
               a = AW'(w * 4);
               exp_q.push_back({a, words[w]});
            end
            send_byte(b, gap_max);
         end
      end
      send_byte(cs ^ csum_flip, gap_max);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(5);
      assertions++;
      if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset: got %b, required 1", core_reset); end
      assertions++;
      if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
      assertions++;
      if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
      assertions++;
      if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL reset_status: got busy/done/error=%b, required 000", {busy, done, error}); end
      assertions++;
      if ({mem_waddr, mem_wdata} !== '0) begin failures++; $display("FAIL reset_mem_bus: got addr=%h data=%h, required 0", mem_waddr, mem_wdata); end
      assertions++;
      if (fsm_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d, required 0", fsm_state); end
   endtask

   task automatic test_basic_load();
      int w0;
      w0 = writes_seen;
      words[0] = 32'h0000_0013;
      words[1] = 32'h0010_0093;
      pulse_start();
      assertions++;
      if ({s_ready, busy, core_reset} !== 3'b111) begin failures++; $display("FAIL start_latency: got ready/busy/core_reset=%b, required 111", {s_ready, busy, core_reset}); end
      assertions++;
      if (fsm_state !== 3'd1) begin failures++; $display("FAIL start_state: got %0d, required 1", fsm_state); end
      send_load(2, 8'h00, 0);
      assertions++;
      if ({done, error, busy, core_reset, s_ready} !== 5'b10000) begin failures++; $display("FAIL basic_status: got done/error/busy/core_reset/ready=%b, required 10000", {done, error, busy, core_reset, s_ready}); end
      assertions++;
      if (writes_seen - w0 != 2 || exp_q.size() != 0) begin failures++; $display("FAIL basic_writes: got %0d writes, %0d pending, required 2 and 0", writes_seen - w0, exp_q.size()); end
      idle(1);
      assertions++;
      if ({done, core_reset} !== 2'b10) begin failures++; $display("FAIL basic_hold: got done/core_reset=%b, required 10", {done, core_reset}); end
   endtask

   task automatic test_bad_checksum();
      int w0;
      w0 = writes_seen;
      pulse_start();
      assertions++;
      if ({done, busy} !== 2'b01) begin failures++; $display("FAIL restart_clear: got done/busy=%b, required 01", {done, busy}); end
      send_load(2, 8'h01, 0);
      assertions++;
      if ({error, done, core_reset, busy} !== 4'b1010) begin failures++; $display("FAIL badsum_status: got error/done/core_reset/busy=%b, required 1010", {error, done, core_reset, busy}); end
      assertions++;
      if (writes_seen - w0 != 2 || exp_q.size() != 0) begin failures++; $display("FAIL badsum_writes: got %0d writes, %0d pending, required 2 and 0", writes_seen - w0, exp_q.size()); end
   endtask

   task automatic test_oversize();
      int w0;
      w0 = writes_seen;
      pulse_start();
      assertions++;
      if ({error, busy} !== 2'b01) begin failures++; $display("FAIL oversize_start: got error/busy=%b, required 01", {error, busy}); end
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      assertions++;
      if ({error, s_ready, busy, core_reset} !== 4'b1001) begin failures++; $display("FAIL oversize_status: got error/ready/busy/core_reset=%b, required 1001", {error, s_ready, busy, core_reset}); end
      idle(3);
      assertions++;
      if (writes_seen != w0 || fsm_state !== 3'd6) begin failures++; $display("FAIL oversize_nowrite: got %0d writes state %0d, required 0 writes state 6", writes_seen - w0, fsm_state); end
   endtask

   task automatic test_zero_len();
      int w0;
      w0 = writes_seen;
      pulse_start();
      start = 1'b1;
      send_byte(8'h00, 0);
      start = 1'b0;
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      assertions++;
      if ({done, error, busy, core_reset} !== 4'b1000) begin failures++; $display("FAIL zero_status: got done/error/busy/core_reset=%b, required 1000", {done, error, busy, core_reset}); end
      assertions++;
      if (writes_seen != w0) begin failures++; $display("FAIL zero_nowrite: got %0d writes, required 0", writes_seen - w0); end
   endtask

   task automatic test_gaps();
      int w0;
      w0 = writes_seen;
      words[0] = 32'h0000_0013;
      words[1] = 32'h0010_0093;
      pulse_start();
      send_load(2, 8'h00, 3);
      assertions++;
      if ({done, error, core_reset} !== 3'b100) begin failures++; $display("FAIL gaps_status: got done/error/core_reset=%b, required 100", {done, error, core_reset}); end
      assertions++;
      if (writes_seen - w0 != 2 || exp_q.size() != 0) begin failures++; $display("FAIL gaps_writes: got %0d writes, %0d pending, required 2 and 0", writes_seen - w0, exp_q.size()); end
   endtask

   task automatic test_reset_mid_load();
      int w0;
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      reset = 1'b0;
      idle(1);
      reset = 1'b1;
      assertions++;
      if (fsm_state !== 3'd0 || {busy, s_ready, core_reset, done, error, mem_we} !== 6'b001000) begin
         failures++;
         $display("FAIL midreset_state: got state %0d busy/ready/core_reset/done/error/we=%b, required 0 and 001000", fsm_state, {busy, s_ready, core_reset, done, error, mem_we});
      end
      idle(2);
      for (int i = 0; i < 3; i++) words[i] = $urandom;
      w0 = writes_seen;
      pulse_start();
      send_load(3, 8'h00, 2);
      assertions++;
      if ({done, error, core_reset} !== 3'b100) begin failures++; $display("FAIL reload_status: got done/error/core_reset=%b, required 100", {done, error, core_reset}); end
      assertions++;
      if (writes_seen - w0 != 3 || exp_q.size() != 0) begin failures++; $display("FAIL reload_writes: got %0d writes, %0d pending, required 3 and 0", writes_seen - w0, exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int w0;
      for (int i = 0; i < 512; i++) words[i] = $urandom;
      w0 = writes_seen;
      pulse_start();
      assertions++;
      if ({done, busy, core_reset} !== 3'b011) begin failures++; $display("FAIL b2b_start: got done/busy/core_reset=%b, required 011", {done, busy, core_reset}); end
      send_load(512, 8'h00, 0);
      assertions++;
      if ({done, error, busy, core_reset} !== 4'b1000) begin failures++; $display("FAIL b2b_status: got done/error/busy/core_reset=%b, required 1000", {done, error, busy, core_reset}); end
      assertions++;
      if (writes_seen - w0 != 512 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_writes: got %0d writes, %0d pending, required 512 and 0", writes_seen - w0, exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_bad_checksum();
      test_oversize();
      test_zero_len();
      test_gaps();
      test_reset_mid_load();
      test_back_to_back();
      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction memory write port. It verifies a trailing checksum and holds the core's PC register in reset until a load completes successfully. It sits between the host/debug byte link and the instruction memory, and owns `reset_pc` for the fetch stage.

## Interface

- `ADDR_WIDTH`, default 11, instruction memory byte-address width. It matches the address width the fetch stage uses.
- `MAX_WORDS`, default 2**(ADDR_WIDTH-2) = 512, is the largest accepted word count.

- `clock`  in  1  single clock.
- `reset`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load. It is honoured only in IDLE, DONE or ERROR.
- `s_valid`  in  1  byte stream valid.
- `s_data`  in  8  byte stream data.
- `s_ready`  out  1  the loader accepts a byte when `s_valid & s_ready`.
- `mem_we`  out  1  instruction memory write enable, one-cycle pulse.
- `mem_waddr`  out  ADDR_WIDTH  byte address, always word-aligned (bits [1:0] = 0).
- `mem_wdata`  out  32  instruction word.
- `core_reset`  out  1  active-high, drives fetch `reset_pc`.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load succeeded. It stays set until the next `start` or `reset`.
- `error`  out  1  the last load failed. It stays set until the next `start` or `reset`.

## Operation

- Stream format, in order:
  - Word count N: 16-bit little-endian, low byte first.
  - N×4 payload bytes: each word is little-endian, first byte goes to [7:0].
  - One checksum byte: the XOR of all payload bytes. The count bytes are excluded.
- States: IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR.
- IDLE:
  - `s_ready`=0, `core_reset`=1.
  - `start` → LEN0.
- LEN0: accept the low count byte → LEN1.
- LEN1: accept the high count byte, then:
  - N > MAX_WORDS → ERROR.
  - N = 0 → CHECK.
  - Otherwise → DATA.
- DATA:
  - A 2-bit byte index and a word index both start at 0.
  - Each accepted byte goes into lane [8·idx+7 : 8·idx] and is XORed into the checksum register.
  - On the 4th byte, the assembled word is written with `mem_waddr` = word_idx×4.
  - After word N−1 is written → CHECK.
- CHECK:
  - Accept one byte.
  - Equal to the checksum register → DONE. Otherwise → ERROR.
- DONE: `done`=1, `core_reset`=0, `s_ready`=0.
- ERROR: `error`=1, `core_reset`=1, `s_ready`=0.
- `start` in IDLE, DONE or ERROR:
  - Clears `done`, `error`, the checksum, and both indices.
  - Sets `busy`=1 and `core_reset`=1.
  - Next state is LEN0.
- `start` while busy (LEN0..CHECK) is ignored.
- `s_ready`=1 in LEN0, LEN1, DATA and CHECK. The loader never back-pressures, because memory accepts a write every cycle.
- `busy`=1 exactly in LEN0..CHECK.
- Memory contents are never cleared. Words beyond N keep their previous values.
- Reset mid-load returns everything to IDLE with the reset values below. Partially written memory stays as written.

## Timing

- Reset values:
  - State IDLE.
  - `s_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0.
  - `core_reset`=1.
  - `busy`=0, `done`=0, `error`=0.
- All outputs are registered.
- `start` sampled high in cycle t → LEN0 and `s_ready`=1 in cycle t+1.
- 4th byte of a word accepted in cycle t → `mem_we`=1 with valid `mem_waddr`/`mem_wdata` in cycle t+1 only. Memory captures the write at the end of t+1.
- The last word's write pulse coincides with the first CHECK cycle. Back-to-back words can therefore produce `mem_we` on consecutive 4-cycle boundaries.
- Checksum byte accepted in cycle t:
  - Match → `done`=1, `busy`=0, `core_reset`=0 in t+1. The fetch PC leaves reset with the PC at 0 at t+2.
  - Mismatch → `error`=1, `busy`=0 in t+1, and `core_reset` stays 1.
- Oversize count → `error`=1 in the cycle after the high count byte. No `mem_we` occurs.
- Gaps in `s_valid` stall the FSM with no state change.
- `mem_waddr` wraps never: N ≤ MAX_WORDS guarantees the highest address is (MAX_WORDS−1)×4.

## Test plan

- Reset held 2 cycles, then idle for 5 cycles → `core_reset`=1, `s_ready`=0, `mem_we`=0, `busy`/`done`/`error`=0.
- `start`, then bytes 02 00 13 00 00 00 93 00 10 00 90 with `s_valid` continuous:
  - Write pulse 1: `mem_waddr`=0x000, `mem_wdata`=0x00000013.
  - Write pulse 2: `mem_waddr`=0x004, `mem_wdata`=0x00100093.
  - Then `done`=1 and `core_reset`=0 one cycle after the 0x90 byte.
- Same stream with checksum 0x91 → both writes still occur, `error`=1, `done`=0, `core_reset`=1.
- Count bytes 01 02 (N=513) → `error`=1 after the second byte, no `mem_we`, `s_ready`=0.
- Count 00 00 then checksum 00 → `done`=1, no `mem_we`. A `start` issued during LEN0 is ignored.
- Random 0–3 cycle `s_valid` gaps in the 2-word load → identical writes. Separately, `reset` after the 5th byte → IDLE; a fresh full load then succeeds with the correct writes.
